// File: rtl/uart_rx_autobaud.sv
// RX pad conditioning (synchronizer + majority deglitch), bit-period measurement
// from an 0x55 sync character, and line-break detection.
module uart_rx_autobaud #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_LEN   = 3,
    parameter int CNT_WIDTH    = 24,
    parameter int MIN_DIV      = 4,
    parameter int IDLE_CYCLES  = 64,
    parameter int BREAK_BITS   = 11,
    parameter int BREAK_UNLOCK = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 rx_pad_i,
    output logic                 rx_o,
    output logic [CNT_WIDTH-1:0] baud_div_o,
    output logic                 baud_valid_o,
    output logic                 locked_o,
    output logic                 break_o,
    output logic                 err_o
);

    localparam int IDLE_W    = $clog2(IDLE_CYCLES + 1);
    localparam int BRK_MUL_W = CNT_WIDTH + $clog2(BREAK_BITS + 1);
    localparam int BRK_ABS_W = $clog2(BREAK_UNLOCK + 1);
    localparam int BRK_W     = (BRK_MUL_W > BRK_ABS_W) ? BRK_MUL_W : BRK_ABS_W;

    localparam logic [2:0] WAIT_IDLE = 3'd0;
    localparam logic [2:0] ARMED     = 3'd1;
    localparam logic [2:0] MEASURE   = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] LOCKED    = 3'd4;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic [FILTER_LEN-1:0]  filt_p1;
    logic                   rx_prev_p3;

    logic [2:0]             state;
    logic [IDLE_W-1:0]      idle_cnt;
    logic [CNT_WIDTH-1:0]   total_cnt;
    logic [CNT_WIDTH-1:0]   since_cnt;
    logic [CNT_WIDTH-1:0]   ref_len;
    logic [CNT_WIDTH-1:0]   div_q;
    logic [CNT_WIDTH-1:0]   stop_cnt;
    logic                   have_ref;
    logic [2:0]             fall_cnt;
    logic [BRK_W-1:0]       brk_cnt;

    logic                   rx_fall;
    logic                   rx_rise;
    logic                   rx_edge;
    logic [CNT_WIDTH-1:0]   total_n;
    logic [CNT_WIDTH-1:0]   since_n;
    logic [CNT_WIDTH-1:0]   stop_n;
    logic [CNT_WIDTH-1:0]   div_n;
    logic [CNT_WIDTH:0]     div_x2;
    logic                   in_window;
    logic                   reject;
    logic [BRK_W-1:0]       brk_n;
    logic [BRK_W-1:0]       brk_thr;

    function automatic logic majority(input logic [FILTER_LEN-1:0] s);
        int ones;
        ones = 0;
        for (int i = 0; i < FILTER_LEN; i++) begin
            ones += int'(s[i]);
        end
        return (ones > FILTER_LEN / 2);
    endfunction

    // Eight bit times are accumulated; divide by 8 with round-half-up.
    function automatic logic [CNT_WIDTH-1:0] round_div8(input logic [CNT_WIDTH-1:0] t);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, t} + (CNT_WIDTH + 1)'(4);
        return CNT_WIDTH'(s >> 3);
    endfunction

    function automatic logic [BRK_W-1:0] sat_inc_brk(input logic [BRK_W-1:0] c);
        return (c == '1) ? c : c + BRK_W'(1);
    endfunction

    // Stage p0: pad synchronizer
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_p0 <= '1;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], rx_pad_i};
        end
    end

    // Stage p1: deglitch window; stage p2: registered majority (rx_o)
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            filt_p1    <= '1;
            rx_o       <= 1'b1;
            rx_prev_p3 <= 1'b1;
        end else begin
            filt_p1    <= {filt_p1[FILTER_LEN-2:0], sync_p0[SYNC_STAGES-1]};
            rx_o       <= majority(filt_p1);
            rx_prev_p3 <= rx_o;
        end
    end

    assign rx_fall   = rx_prev_p3 & ~rx_o;
    assign rx_rise   = ~rx_prev_p3 & rx_o;
    assign rx_edge   = rx_fall | rx_rise;

    assign total_n   = total_cnt + CNT_WIDTH'(1);
    assign since_n   = since_cnt + CNT_WIDTH'(1);
    assign stop_n    = stop_cnt + CNT_WIDTH'(1);
    assign div_n     = round_div8(total_n);
    assign div_x2    = {div_q, 1'b0};
    assign in_window = (since_n >= (ref_len >> 1)) && ({1'b0, since_n} <= {ref_len, 1'b0});

    // Edge 2 only establishes the reference, so its interval is never rejected.
    always_comb begin
        reject = 1'b0;
        case (state)
            MEASURE: begin
                reject = (total_n == '1)
                      || (rx_edge && have_ref && !in_window)
                      || (rx_fall && have_ref && (fall_cnt == 3'd4) && (div_n < CNT_WIDTH'(MIN_DIV)));
            end
            STOP: begin
                reject = !rx_rise && ({1'b0, stop_n} >= div_x2);
            end
            default: reject = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= WAIT_IDLE;
            idle_cnt     <= '0;
            total_cnt    <= '0;
            since_cnt    <= '0;
            ref_len      <= '0;
            div_q        <= '0;
            stop_cnt     <= '0;
            have_ref     <= 1'b0;
            fall_cnt     <= '0;
            baud_div_o   <= '0;
            baud_valid_o <= 1'b0;
            locked_o     <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            baud_valid_o <= 1'b0;
            err_o        <= 1'b0;
            if (!enable_i) begin
                state    <= WAIT_IDLE;
                idle_cnt <= '0;
                locked_o <= 1'b0;
            end else if (reject) begin
                state    <= WAIT_IDLE;
                idle_cnt <= '0;
                locked_o <= 1'b0;
                err_o    <= 1'b1;
            end else begin
                case (state)
                    WAIT_IDLE: begin
                        if (!rx_o) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_W'(IDLE_CYCLES - 1)) begin
                            idle_cnt <= '0;
                            state    <= ARMED;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                    ARMED: begin
                        if (rx_fall) begin
                            total_cnt <= '0;
                            since_cnt <= '0;
                            have_ref  <= 1'b0;
                            fall_cnt  <= 3'd1;
                            state     <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        total_cnt <= total_n;
                        since_cnt <= since_n;
                        if (rx_edge) begin
                            since_cnt <= '0;
                            if (!have_ref) begin
                                ref_len  <= since_n;
                                have_ref <= 1'b1;
                            end else if (rx_fall) begin
                                if (fall_cnt == 3'd4) begin
                                    div_q    <= div_n;
                                    stop_cnt <= '0;
                                    state    <= STOP;
                                end else begin
                                    fall_cnt <= fall_cnt + 3'd1;
                                end
                            end
                        end
                    end
                    STOP: begin
                        if (rx_rise) begin
                            baud_div_o   <= div_q;
                            baud_valid_o <= 1'b1;
                            locked_o     <= 1'b1;
                            state        <= LOCKED;
                        end else begin
                            stop_cnt <= stop_n;
                        end
                    end
                    LOCKED: begin
                        state <= LOCKED;
                    end
                    default: begin
                        state <= WAIT_IDLE;
                    end
                endcase
            end
        end
    end

    // Break threshold scales with the locked bit period, else a fixed clock count.
    assign brk_thr = locked_o ? BRK_W'(BREAK_BITS) * BRK_W'(baud_div_o) : BRK_W'(BREAK_UNLOCK);
    assign brk_n   = sat_inc_brk(brk_cnt);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            brk_cnt <= '0;
            break_o <= 1'b0;
        end else if (rx_o) begin
            brk_cnt <= '0;
            break_o <= 1'b0;
        end else begin
            brk_cnt <= brk_n;
            if (brk_n >= brk_thr) begin
                break_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_autobaud.sv
// Directed + randomized bench for uart_rx_autobaud; frame outcomes come from a
// waveform-level model of the autobaud rules.
module tb_uart_rx_autobaud;

    localparam int CW         = 24;
    localparam int MIN_DIV    = 4;
    localparam int IDLE       = 64;
    localparam int BREAK_BITS = 11;
    localparam int LAT        = 2 + (3 + 1) / 2 + 1;
    localparam int R_NONE     = 0;
    localparam int R_LOCK     = 1;
    localparam int R_ERR      = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          pad;
    logic          rx_o;
    logic [CW-1:0] baud_div_o;
    logic          baud_valid_o;
    logic          locked_o;
    logic          break_o;
    logic          err_o;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int exp_div  = 0;

    always #5 clk = ~clk;

    uart_rx_autobaud #(
        .SYNC_STAGES(2), .FILTER_LEN(3), .CNT_WIDTH(CW), .MIN_DIV(MIN_DIV),
        .IDLE_CYCLES(IDLE), .BREAK_BITS(BREAK_BITS), .BREAK_UNLOCK(4096)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .rx_pad_i(pad),
        .rx_o(rx_o), .baud_div_o(baud_div_o), .baud_valid_o(baud_valid_o),
        .locked_o(locked_o), .break_o(break_o), .err_o(err_o)
    );

    always @(negedge clk) begin
        if (baud_valid_o === 1'b1) n_valid <= n_valid + 1;
        if (err_o === 1'b1) n_err <= n_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit frame_level(input logic [7:0] b, input int t, input int c);
        int idx;
        idx = c / t;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    // Walks the ideal line waveform of one 8N1 frame and applies the autobaud rules.
    function automatic void model_frame(input logic [7:0] b, input int t, output int res, output int dv);
        bit prev, lvl, waiting_stop;
        int last_t, ref_i, nedge, nfall, gap, fall5_t;
        res = R_NONE; dv = 0; prev = 1'b1; waiting_stop = 1'b0;
        last_t = 0; ref_i = 0; nedge = 0; nfall = 0; fall5_t = 0;
        for (int c = 0; c < 12 * t; c++) begin
            lvl = frame_level(b, t, c);
            if (waiting_stop) begin
                if (lvl) begin
                    res = (c - fall5_t <= 2 * dv) ? R_LOCK : R_ERR;
                    return;
                end
                if (c - fall5_t >= 2 * dv) begin
                    res = R_ERR;
                    return;
                end
            end else if (lvl != prev) begin
                nedge++;
                gap = c - last_t;
                last_t = c;
                if (nedge == 2) ref_i = gap;
                else if (nedge > 2 && (gap < ref_i / 2 || gap > 2 * ref_i)) begin
                    res = R_ERR;
                    return;
                end
                if (!lvl) begin
                    nfall++;
                    if (nfall == 5) begin
                        dv = (c + 4) / 8;
                        if (dv < MIN_DIV) begin
                            res = R_ERR;
                            return;
                        end
                        waiting_stop = 1'b1;
                        fall5_t = c;
                    end
                end
            end
            prev = lvl;
        end
    endfunction

    task automatic send_frame(input logic [7:0] b, input int t, input int kill_at);
        for (int c = 0; c < 12 * t + 20; c++) begin
            pad = frame_level(b, t, c);
            if (c == kill_at) enable = 1'b0;
            step(1);
        end
    endtask

    task automatic arm();
        enable = 1'b0;
        step(2);
        enable = 1'b1;
        step(IDLE + 16);
    endtask

    task automatic run_frame(input logic [7:0] b, input int t);
        int res, dv, v0, e0;
        arm();
        model_frame(b, t, res, dv);
        v0 = n_valid;
        e0 = n_err;
        send_frame(b, t, -1);
        if (res == R_LOCK) exp_div = dv;
        chk("rand_valid_cnt", n_valid - v0, (res == R_LOCK) ? 1 : 0);
        chk("rand_err_cnt", n_err - e0, (res == R_ERR) ? 1 : 0);
        chk("rand_locked", locked_o, (res == R_LOCK) ? 1 : 0);
        chk("rand_baud_div", baud_div_o, exp_div);
    endtask

    initial begin
        int v0, e0, t;
        logic [7:0] b;

        // Reset with the pad idle high.
        rst_n = 1'b0; enable = 1'b0; pad = 1'b1;
        step(3);
        chk("rst_rx", rx_o, 1);
        chk("rst_div", baud_div_o, 0);
        chk("rst_valid", baud_valid_o, 0);
        chk("rst_locked", locked_o, 0);
        chk("rst_break", break_o, 0);
        chk("rst_err", err_o, 0);
        rst_n = 1'b1;
        step(10);

        // Deglitch: a 1-cycle pulse vanishes, a 4-cycle pulse passes intact.
        pad = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            pad = 1'b1;
            chk("glitch1_rx", rx_o, 1);
        end
        pad = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (k >= 4) pad = 1'b1;
            chk("pulse4_rx", rx_o, (k >= LAT && k <= LAT + 3) ? 0 : 1);
        end
        step(10);

        // A sync char arriving before 64 idle cycles must not be measured.
        enable = 1'b1;
        step(40);
        v0 = n_valid; e0 = n_err;
        send_frame(8'h55, 10, -1);
        chk("early_valid_cnt", n_valid - v0, 0);
        chk("early_locked", locked_o, 0);

        step(IDLE + 16);
        v0 = n_valid;
        send_frame(8'h55, 100, -1);
        exp_div = 100;
        chk("lock100_valid_cnt", n_valid - v0, 1);
        chk("lock100_div", baud_div_o, 100);
        chk("lock100_locked", locked_o, 1);

        arm();
        v0 = n_valid;
        send_frame(8'h55, 97, -1);
        exp_div = 97;
        chk("lock97_valid_cnt", n_valid - v0, 1);
        chk("lock97_div", baud_div_o, 97);
        chk("lock97_locked", locked_o, 1);

        // 0x0F rejected; a following 0x55 locks without toggling enable.
        arm();
        v0 = n_valid; e0 = n_err;
        send_frame(8'h0F, 100, -1);
        chk("bad0f_err_cnt", n_err - e0, 1);
        chk("bad0f_valid_cnt", n_valid - v0, 0);
        chk("bad0f_locked", locked_o, 0);
        chk("bad0f_div", baud_div_o, 97);
        step(IDLE + 16);
        send_frame(8'h55, 100, -1);
        exp_div = 100;
        chk("relock_div", baud_div_o, 100);
        chk("relock_locked", locked_o, 1);

        // Break while locked at 100: threshold is 11 bit times.
        e0 = n_err;
        pad = 1'b0;
        for (int c = 1; c <= 1210; c++) begin
            step(1);
            if (c == LAT + BREAK_BITS * 100 - 1) chk("brk_before", break_o, 0);
            if (c == LAT + BREAK_BITS * 100) chk("brk_set", break_o, 1);
            if (c == 1200 + LAT) begin
                chk("brk_rx_high", rx_o, 1);
                chk("brk_held", break_o, 1);
            end
            if (c == 1200 + LAT + 1) chk("brk_clear", break_o, 0);
            if (c == 1200) pad = 1'b1;
        end
        chk("brk_locked", locked_o, 1);
        chk("brk_no_err", n_err - e0, 0);

        // Unlocked: 1200 low cycles stay below the 4096-cycle threshold.
        enable = 1'b0;
        pad = 1'b0;
        step(1200);
        chk("brk_unlocked", break_o, 0);
        chk("dis_locked", locked_o, 0);
        pad = 1'b1;
        step(20);

        // enable drops on the very cycle the stop edge is seen: no result.
        arm();
        v0 = n_valid; e0 = n_err;
        send_frame(8'h55, 40, 9 * 40 + LAT);
        chk("kill_valid_cnt", n_valid - v0, 0);
        chk("kill_err_cnt", n_err - e0, 0);
        chk("kill_locked", locked_o, 0);
        chk("kill_div", baud_div_o, 100);

        // MIN_DIV boundary, then randomized frames.
        run_frame(8'h55, MIN_DIV - 1);
        run_frame(8'h55, MIN_DIV);
        for (int i = 0; i < 6; i++) begin
            b = ($urandom_range(0, 1) == 1) ? 8'h55 : 8'($urandom);
            t = $urandom_range(3, 60);
            run_frame(b, t);
        end

        // Reset in the middle of a measurement.
        arm();
        for (int c = 0; c < 450; c++) begin
            pad = frame_level(8'h55, 100, c);
            step(1);
        end
        rst_n = 1'b0;
        step(1);
        chk("midrst_rx", rx_o, 1);
        chk("midrst_div", baud_div_o, 0);
        chk("midrst_locked", locked_o, 0);
        chk("midrst_valid", baud_valid_o, 0);
        chk("midrst_err", err_o, 0);
        chk("midrst_break", break_o, 0);
        rst_n = 1'b1;
        pad = 1'b1;
        step(IDLE + 16);
        send_frame(8'h55, 50, -1);
        chk("lock50_div", baud_div_o, 50);
        chk("lock50_locked", locked_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
